// File: rtl/free_list_pkg.sv
// Shared rename types: physical register index and free-list pointer widths.
package free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PW        = $clog2(NUM_PREGS);
  localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int PTR_W     = IDX_W + 1;

  typedef logic [PW-1:0]    preg_t;
  typedef logic [PTR_W-1:0] fl_ptr_t;

  localparam fl_ptr_t WRAP_BIT = fl_ptr_t'(1) << IDX_W;
endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers; refilled by retirement, drained by
// rename, and restored to full in a single cycle on flush.
module free_list
  import free_list_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  preg_t            pd_in,
  input  logic             deq,
  input  logic             flush,
  output preg_t            pd_out,
  output logic             valid,
  output logic             full,
  output logic [PTR_W-1:0] count,
  output logic             overflow
);

  preg_t   entries [DEPTH];
  fl_ptr_t head, tail;
  fl_ptr_t head_nxt, tail_nxt;
  logic    enq_v, enq_ok, deq_ok, ovf_set;

  assign valid  = (head != tail);
  assign full   = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign count  = tail - head;
  assign pd_out = entries[head[IDX_W-1:0]];

  // p0 backs x0 and never becomes free, so it is filtered before anything else.
  assign enq_v  = enq && (pd_in != '0);
  assign deq_ok = deq && valid && !flush;
  // A full list can still accept a write when the head slot is vacated this cycle.
  assign enq_ok  = enq_v && (!full || deq_ok);
  assign ovf_set = enq_v && full && !deq_ok && !flush;

  always_comb begin
    tail_nxt = tail;
    head_nxt = head;
    if (enq_ok)
      tail_nxt = tail + fl_ptr_t'(1);
    if (flush)
      head_nxt = tail_nxt ^ WRAP_BIT;
    else if (deq_ok)
      head_nxt = head + fl_ptr_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= preg_t'(NUM_AREGS + i);
      head     <= '0;
      tail     <= fl_ptr_t'(DEPTH);
      overflow <= 1'b0;
    end else begin
      if (enq_ok)
        entries[tail[IDX_W-1:0]] <= pd_in;
      head <= head_nxt;
      tail <= tail_nxt;
      if (ovf_set)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Scenario bench for free_list: expected pd_out values queued per scenario.
module tb_free_list;
  import free_list_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enq = 1'b0;
  preg_t            pd_in = '0;
  logic             deq = 1'b0;
  logic             flush = 1'b0;
  preg_t            pd_out;
  logic             valid;
  logic             full;
  logic [PTR_W-1:0] count;
  logic             overflow;

  int    n_tests = 0;
  int    n_fail  = 0;
  preg_t exp_q[$];

  free_list dut (
    .clk(clk), .rst(rst), .enq(enq), .pd_in(pd_in), .deq(deq), .flush(flush),
    .pd_out(pd_out), .valid(valid), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic e, input preg_t p, input logic d, input logic f);
    enq = e; pd_in = p; deq = d; flush = f;
    @(posedge clk); #1;
    enq = 1'b0; pd_in = '0; deq = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Pops one expected value, compares pd_out, then issues the dequeue.
  task automatic deq_check(input string name);
    preg_t e;
    e = exp_q.pop_front();
    n_tests++;
    if (!valid || pd_out !== e) begin
      n_fail++;
      $display("FAIL %s: pd_out=%0d valid=%0b, expected pd_out=%0d valid=1", name, pd_out, valid, e);
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (count !== 6'd32 || full !== 1'b1 || valid !== 1'b1 || pd_out !== 6'd32 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d full=%0b valid=%0b pd_out=%0d ovf=%0b, expected 32 1 1 32 0",
               count, full, valid, pd_out, overflow);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(preg_t'(32 + i));
    for (int i = 0; i < 3; i++) deq_check("reset_deq");
    n_tests++;
    if (pd_out !== 6'd35 || count !== 6'd29) begin
      n_fail++;
      $display("FAIL after_3_deq: pd_out=%0d count=%0d, expected 35 29", pd_out, count);
    end
  endtask

  task automatic test_drain_refill();
    do_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(preg_t'(32 + i));
    for (int i = 0; i < 32; i++) deq_check("drain_seq");
    n_tests++;
    if (valid !== 1'b0 || count !== 6'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%0b count=%0d full=%0b, expected 0 0 0", valid, count, full);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (valid !== 1'b0 || count !== 6'd0) begin
      n_fail++;
      $display("FAIL deq_when_empty: valid=%0b count=%0d, expected 0 0", valid, count);
    end
    step(1'b1, 6'b100000, 1'b0, 1'b0);
    n_tests++;
    if (valid !== 1'b1 || count !== 6'd1 || pd_out !== 6'd32) begin
      n_fail++;
      $display("FAIL refill_first: valid=%0b count=%0d pd_out=%0d, expected 1 1 32", valid, count, pd_out);
    end
    step(1'b1, 6'b110011, 1'b0, 1'b0);
    exp_q.push_back(6'd32);
    exp_q.push_back(6'd51);
    n_tests++;
    if (count !== 6'd2) begin
      n_fail++;
      $display("FAIL refill_count: count=%0d, expected 2", count);
    end
    deq_check("refill_seq");
    step(1'b1, 6'd0, 1'b0, 1'b0);
    n_tests++;
    if (count !== 6'd1 || pd_out !== 6'd51) begin
      n_fail++;
      $display("FAIL enq_p0_dropped: count=%0d pd_out=%0d, expected 1 51", count, pd_out);
    end
    deq_check("refill_seq");
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 6'd12, 1'b1, 1'b0);
    n_tests++;
    if (count !== 6'd32 || full !== 1'b1 || overflow !== 1'b0 || pd_out !== 6'd33) begin
      n_fail++;
      $display("FAIL full_enq_deq: count=%0d full=%0b ovf=%0b pd_out=%0d, expected 32 1 0 33",
               count, full, overflow, pd_out);
    end
    do_reset();
    for (int i = 0; i < 27; i++) step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (count !== 6'd5 || pd_out !== 6'd59) begin
      n_fail++;
      $display("FAIL setup_count5: count=%0d pd_out=%0d, expected 5 59", count, pd_out);
    end
    step(1'b1, 6'd7, 1'b1, 1'b0);
    n_tests++;
    if (count !== 6'd5) begin
      n_fail++;
      $display("FAIL enq_deq_count5: count=%0d, expected 5", count);
    end
    for (int i = 60; i < 64; i++) exp_q.push_back(preg_t'(i));
    exp_q.push_back(6'd7);
    for (int i = 0; i < 5; i++) deq_check("simul_drain");
    step(1'b1, 6'd9, 1'b1, 1'b0);
    n_tests++;
    if (count !== 6'd1 || valid !== 1'b1 || pd_out !== 6'd9) begin
      n_fail++;
      $display("FAIL empty_enq_deq: count=%0d valid=%0b pd_out=%0d, expected 1 1 9", count, valid, pd_out);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back(preg_t'(32 + i));
    for (int i = 0; i < 10; i++) deq_check("flush_alloc");
    step(1'b1, 6'd5, 1'b0, 1'b0);
    n_tests++;
    if (count !== 6'd23) begin
      n_fail++;
      $display("FAIL pre_flush_count: count=%0d, expected 23", count);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    n_tests++;
    if (count !== 6'd32 || full !== 1'b1 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: count=%0d full=%0b valid=%0b, expected 32 1 1", count, full, valid);
    end
    // Slot 0 (p32) was overwritten by p5, so recovery starts at slot 1.
    for (int i = 33; i < 64; i++) exp_q.push_back(preg_t'(i));
    exp_q.push_back(6'd5);
    for (int i = 0; i < 32; i++) deq_check("flush_recover");
    n_tests++;
    if (valid !== 1'b0 || count !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_drained: valid=%0b count=%0d, expected 0 0", valid, count);
    end
  endtask

  task automatic test_overflow_async_reset();
    do_reset();
    step(1'b1, 6'd20, 1'b0, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || count !== 6'd32 || pd_out !== 6'd32) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%0b count=%0d pd_out=%0d, expected 1 32 32", overflow, count, pd_out);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    n_tests++;
    if (overflow !== 1'b1 || count !== 6'd30 || pd_out !== 6'd34) begin
      n_fail++;
      $display("FAIL overflow_sticky: ovf=%0b count=%0d pd_out=%0d, expected 1 30 34", overflow, count, pd_out);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (count !== 6'd32 || full !== 1'b1 || valid !== 1'b1 || pd_out !== 6'd32 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d full=%0b valid=%0b pd_out=%0d ovf=%0b, expected 32 1 1 32 0",
               count, full, valid, pd_out, overflow);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (count !== 6'd32 || pd_out !== 6'd32 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: count=%0d pd_out=%0d ovf=%0b, expected 32 32 0", count, pd_out, overflow);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_drain_refill();
    test_simultaneous();
    test_flush();
    test_overflow_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
